// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared definitions for the parametrised synchronous FIFO.
//   ptr_width() - address width for a given entry count ($clog2 wrapper).
//   fifo_mode_e - read mode selected by the FWFT parameter of sfifo_param.
package sfifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,   // registered read, one-cycle latency
        FIFO_FWFT = 1'b1    // head word presented combinationally on dout
    } fifo_mode_e;

    // Address width for a power-of-two depth. Pointers of this width wrap
    // naturally from depth-1 back to 0.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic fifo_mode_e mode_of(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram: WIDTH x DEPTH storage array for sfifo_param.
//   clk           - write clock (rising edge)
//   we/waddr/wdata - synchronous write port
//   raddr/rdata   - asynchronous (combinational) read port
// Contents are deliberately not reset.
module sfifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty flags, sticky error flags, synchronous flush
// and selectable standard / first-word-fall-through read mode.
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   flush          - synchronous clear of contents and error flags
//   we, din        - write request and data
//   re             - read request (FWFT: pop of the word shown on dout)
//   dout, rd_valid - read data and its qualifier
//   full, empty, almost_full, almost_empty, count - occupancy status
//   overflow, underflow - sticky error flags, cleared by flush/reset
//
// Handshake: a write is accepted when we is high and the FIFO is not full,
// or is full but a read is accepted in the same cycle (the read frees the
// slot). A read is accepted when re is high and the FIFO is not empty;
// there is no same-cycle bypass from din to dout. Requests that are not
// accepted are dropped and recorded in the sticky error flags.
module sfifo_param
    import sfifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   we,
    input  logic [WIDTH-1:0]       din,
    input  logic                   re,
    output logic [WIDTH-1:0]       dout,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int         PW   = ptr_width(DEPTH);
    localparam int         CW   = PW + 1;
    localparam fifo_mode_e MODE = mode_of(FWFT);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [WIDTH-1:0] ram_rdata;
    logic             rd_acc;
    logic             wr_acc;

    // Status flags are pure decodes of the occupancy count.
    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign rd_acc = re & ~empty;
    assign wr_acc = we & (~full | rd_acc);

    sfifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~flush),
        .waddr (wptr),
        .wdata (din),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    // Pointers, count and sticky errors. Flush outranks any request in the
    // same cycle, so its write is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (we && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (MODE == FIFO_STD) begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             rd_valid_q;

            // dout only changes on an accepted read; it holds otherwise,
            // including across a flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= ram_rdata;
                    end
                end
            end

            assign dout     = dout_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head word is always presented; re acknowledges it.
            assign dout     = ram_rdata;
            assign rd_valid = ~empty;
        end
    endgenerate

endmodule
